// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I execute stage: forwarding, ALU, branch resolve, load-use detect, EX/MEM register.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ALUSrcE,
  input  logic            RegWriteE,
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic            MemToRegE,
  input  logic            BranchE,
  input  logic            BNEE,
  input  logic            JMPE,
  input  logic [1:0]      ALUOpE,
  input  logic [XLEN-1:0] ReadData1_E,
  input  logic [XLEN-1:0] ReadData2_E,
  input  logic [XLEN-1:0] ImmOut_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [6:0]      func7E,
  input  logic [2:0]      func3E,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallD,
  output logic            RegWriteM,
  output logic            MemReadM,
  output logic            MemWriteM,
  output logic            MemToRegM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM
);

  logic            reg_write_d, reg_write_q;
  logic            mem_read_d, mem_read_q;
  logic            mem_write_d, mem_write_q;
  logic            mem_to_reg_d, mem_to_reg_q;
  logic [XLEN-1:0] alu_result_d, alu_result_q;
  logic [XLEN-1:0] write_data_d, write_data_q;
  logic [4:0]      rd_d, rd_q;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_out, link;
  logic signed [XLEN-1:0] sra_out;
  logic [4:0]      shamt;
  logic            zero;

  // MEM beats WB; x0 is never a forwarding target.
  always_comb begin
    fwd_a = ReadData1_E;
    if (reg_write_q && (rd_q != 5'd0) && (rd_q == Rs1E)) begin
      fwd_a = alu_result_q;
    end else if (RegWriteW && (RDW != 5'd0) && (RDW == Rs1E)) begin
      fwd_a = ResultW;
    end
    fwd_b = ReadData2_E;
    if (reg_write_q && (rd_q != 5'd0) && (rd_q == Rs2E)) begin
      fwd_b = alu_result_q;
    end else if (RegWriteW && (RDW != 5'd0) && (RDW == Rs2E)) begin
      fwd_b = ResultW;
    end
  end

  assign src_a   = fwd_a;
  assign src_b   = (ALUSrcE || MemWriteE) ? ImmOut_E : fwd_b;
  assign shamt   = src_b[4:0];
  assign sra_out = $signed(src_a) >>> shamt;

  always_comb begin
    alu_out = src_a + src_b;
    case (ALUOpE)
      2'b01: alu_out = src_a - src_b;
      2'b10: begin
        case (func3E)
          3'b000: alu_out = func7E[5] ? (src_a - src_b) : (src_a + src_b);
          3'b001: alu_out = src_a << shamt;
          3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
          3'b011: alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
          3'b100: alu_out = src_a ^ src_b;
          3'b101: alu_out = func7E[5] ? sra_out : (src_a >> shamt);
          3'b110: alu_out = src_a | src_b;
          default: alu_out = src_a & src_b;
        endcase
      end
      default: alu_out = src_a + src_b;
    endcase
  end

  // Branch compare always uses register operands, never the immediate.
  assign zero      = (fwd_a == fwd_b);
  assign PCSrcE    = (BranchE && zero) || (BNEE && !zero) || JMPE;
  assign PCTargetE = PCE + ImmOut_E;
  assign link      = PCE + XLEN'(4);
  assign StallD    = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    reg_write_d  = RegWriteE;
    mem_read_d   = MemReadE;
    mem_write_d  = MemWriteE;
    mem_to_reg_d = MemToRegE;
    alu_result_d = JMPE ? link : alu_out;
    write_data_d = fwd_b;
    rd_d         = RdE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= 5'd0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      rd_q         <= rd_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemReadM   = mem_read_q;
  assign MemWriteM  = mem_write_q;
  assign MemToRegM  = mem_to_reg_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ALUSrcE, RegWriteE, MemReadE, MemWriteE, MemToRegE, BranchE, BNEE, JMPE;
  logic [1:0]  ALUOpE;
  logic [31:0] ReadData1_E, ReadData2_E, ImmOut_E, PCE;
  logic [6:0]  func7E;
  logic [2:0]  func3E;
  logic [4:0]  Rs1E, Rs2E, RdE, Rs1D, Rs2D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        PCSrcE, StallD;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemReadM, MemWriteM, MemToRegM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .MemToRegE(MemToRegE), .BranchE(BranchE), .BNEE(BNEE), .JMPE(JMPE), .ALUOpE(ALUOpE),
    .ReadData1_E(ReadData1_E), .ReadData2_E(ReadData2_E), .ImmOut_E(ImmOut_E), .PCE(PCE),
    .func7E(func7E), .func3E(func3E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemToRegM(MemToRegM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ALUSrcE = 0; RegWriteE = 0; MemReadE = 0; MemWriteE = 0; MemToRegE = 0;
    BranchE = 0; BNEE = 0; JMPE = 0; ALUOpE = 2'b00;
    ReadData1_E = 0; ReadData2_E = 0; ImmOut_E = 0; PCE = 0;
    func7E = 0; func3E = 0; Rs1E = 0; Rs2E = 0; RdE = 0; Rs1D = 0; Rs2D = 0;
    RegWriteW = 0; RDW = 0; ResultW = 0;
  endtask

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input logic imm_src);
    clear_inputs();
    ALUOpE = 2'b10; func3E = f3; func7E = f7;
    Rs1E = 5'd3; Rs2E = 5'd4; RdE = 5'd8;
    ReadData1_E = a;
    if (imm_src) begin ALUSrcE = 1; ImmOut_E = b; end
    else ReadData2_E = b;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    // Arbitrary non-zero inputs during reset.
    ALUSrcE = 1; RegWriteE = 1; MemReadE = 1; MemWriteE = 1; MemToRegE = 1;
    ReadData1_E = 32'h1111_1111; ReadData2_E = 32'h2222_2222; ImmOut_E = 32'h33;
    RdE = 5'd9; ALUOpE = 2'b01;
    step();
    step();
    check("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
    check("rst_memread", {31'd0, MemReadM}, 32'd0);
    check("rst_memwrite", {31'd0, MemWriteM}, 32'd0);
    check("rst_memtoreg", {31'd0, MemToRegM}, 32'd0);
    check("rst_alures", ALUResultM, 32'd0);
    check("rst_wdata", WriteDataM, 32'd0);
    check("rst_rd", {27'd0, RdM}, 32'd0);

    rst = 0;
    clear_inputs();
    RegWriteE = 1; RdE = 5'd10; Rs1E = 5'd1; Rs2E = 5'd2; ReadData1_E = 1; ReadData2_E = 3;
    step();
    check("add_1_3", ALUResultM, 32'h4);
    check("add_rd", {27'd0, RdM}, 32'd10);
    check("add_regwrite", {31'd0, RegWriteM}, 32'd1);

    // Producer for MEM forwarding: x5 <- 0x10.
    clear_inputs();
    RegWriteE = 1; RdE = 5'd5; ALUSrcE = 1; ReadData1_E = 32'h10; ImmOut_E = 0;
    step();
    check("prod_x5", ALUResultM, 32'h10);

    clear_inputs();
    ALUOpE = 2'b10; Rs1E = 5'd5; Rs2E = 5'd6; RdE = 5'd7;
    ReadData1_E = 1; ReadData2_E = 3;
    RegWriteW = 1; RDW = 5'd5; ResultW = 32'h20;
    step();
    check("fwd_m_wins", ALUResultM, 32'h13);
    // The previous instruction had RegWriteE=0, so MEM no longer matches.
    step();
    check("fwd_w", ALUResultM, 32'h23);
    Rs1E = 5'd0; ReadData1_E = 0;
    step();
    check("fwd_x0", ALUResultM, 32'h3);

    // x0 writer in WB must not forward.
    clear_inputs();
    RegWriteW = 1; RDW = 5'd0; ResultW = 32'h99; ReadData2_E = 32'h5;
    step();
    check("fwd_rdw0", ALUResultM, 32'h5);

    // Branches
    clear_inputs();
    PCE = 32'h100; ImmOut_E = 32'hFFFF_FFF8; Rs1E = 5'd1; Rs2E = 5'd2;
    ReadData1_E = 7; ReadData2_E = 7; BranchE = 1;
    #1;
    check("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'hF8);
    BranchE = 0; BNEE = 1;
    #1;
    check("bne_not_taken", {31'd0, PCSrcE}, 32'd0);
    ReadData2_E = 8;
    #1;
    check("bne_taken", {31'd0, PCSrcE}, 32'd1);
    BNEE = 0; ReadData2_E = 7; JMPE = 1; RegWriteE = 1; RdE = 5'd9; ALUSrcE = 1;
    #1;
    check("jmp_taken", {31'd0, PCSrcE}, 32'd1);
    step();
    check("jmp_link", ALUResultM, 32'h104);
    clear_inputs();
    PCE = 32'hFFFF_FFFC; ImmOut_E = 32'h8;
    #1;
    check("target_wrap", PCTargetE, 32'h4);

    // ALU corners
    rtype(3'b101, 7'h20, 32'h8000_0000, 32'd4, 1'b1);
    step();
    check("sra", ALUResultM, 32'hF800_0000);
    rtype(3'b101, 7'h00, 32'h8000_0000, 32'd4, 1'b1);
    step();
    check("srl", ALUResultM, 32'h0800_0000);
    rtype(3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check("slt", ALUResultM, 32'h1);
    rtype(3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    check("sltu", ALUResultM, 32'h0);
    rtype(3'b001, 7'h00, 32'h0000_0003, 32'd4, 1'b0);
    step();
    check("sll", ALUResultM, 32'h30);
    rtype(3'b000, 7'h20, 32'h0000_000A, 32'd3, 1'b0);
    step();
    check("rsub", ALUResultM, 32'h7);
    clear_inputs();
    ALUOpE = 2'b01; ReadData1_E = 0; ReadData2_E = 1; Rs1E = 5'd3; Rs2E = 5'd4;
    step();
    check("sub_wrap", ALUResultM, 32'hFFFF_FFFF);

    // Load-use
    clear_inputs();
    MemReadE = 1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd2;
    #1;
    check("stall_hit", {31'd0, StallD}, 32'd1);
    RdE = 5'd0; Rs2D = 5'd0;
    #1;
    check("stall_rd0", {31'd0, StallD}, 32'd0);
    RdE = 5'd7; Rs2D = 5'd7; MemReadE = 0;
    #1;
    check("stall_noload", {31'd0, StallD}, 32'd0);

    // Store with WB-forwarded data
    clear_inputs();
    step();
    MemWriteE = 1; ImmOut_E = 32'h8; Rs1E = 5'd6; ReadData1_E = 32'h100;
    Rs2E = 5'd4; ReadData2_E = 32'h1234; RegWriteW = 1; RDW = 5'd4; ResultW = 32'hCAFE;
    step();
    check("store_addr", ALUResultM, 32'h108);
    check("store_data", WriteDataM, 32'hCAFE);
    check("store_memwrite", {31'd0, MemWriteM}, 32'd1);

    // Reset mid-operation discards the EX instruction
    clear_inputs();
    RegWriteE = 1; RdE = 5'd3; ReadData1_E = 32'h55; rst = 1;
    step();
    check("midrst_alures", ALUResultM, 32'd0);
    check("midrst_regwrite", {31'd0, RegWriteM}, 32'd0);
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
